alu_control_seq: RTL and testbench
==================================

Name: alu_control_seq

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALU_Op/funct into a 4-bit ALU control code. The funct set is extended with nor and xor.
- Adds a sequencer for multi-cycle mult/multu/div/divu. It drives an iterative MD datapath and stalls the pipeline until the result is ready.
- Sits between the main control unit and the ALU/MD unit; the stall output feeds PC-enable and IF/ID hold.

Parameters:
- ITER, 32, number of MD iteration cycles (one per bit); legal range 1..64.
- CNT_W, $clog2(ITER)+1, local width of the iteration counter; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid  input  1  instruction/alu_op are meaningful this cycle.
- instruction  input  32  current instruction; funct = [5:0].
- alu_op  input  2  00 lw/sw, 01 beq, 10 R-type, 11 addi.
- alu_control  output  4  ALU operation code (combinational).
- md_op  output  2  latched MD op: 00 mult, 01 multu, 10 div, 11 divu.
- md_start  output  1  one-cycle pulse that loads the MD operands.
- md_step  output  1  high for each MD iteration cycle.
- md_done  output  1  one-cycle pulse; the HI/LO result is valid.
- md_busy  output  1  FSM not IDLE.
- stall  output  1  hold PC and IF/ID this cycle.
- illegal_op  output  1  undefined funct under R-type (see Optional Feature).

Behaviour:
- alu_control is combinational and always fully assigned (no latches).
  - alu_op 00 or 11 -> 0010; alu_op 01 -> 0110.
  - alu_op 10, by funct:
    - 100000 add -> 0010
    - 100010 sub -> 0110
    - 100100 and -> 0000
    - 100101 or -> 0001
    - 101010 slt -> 0111
    - 100111 nor -> 1100
    - 100110 xor -> 1101
    - MD functs -> 0010 (don't-care)
    - any other funct -> 0010
- MD start condition: valid & alu_op==10 & funct in {011000 mult, 011001 multu, 011010 div, 011011 divu}.
- FSM states are IDLE, RUN and DONE.
  - IDLE: on the start condition, pulse md_start, latch md_op from funct[1:0], clear the counter, go to RUN; stall=1 combinationally in this cycle. Otherwise remain in IDLE with stall=0.
  - RUN: md_step=1, stall=1, counter increments. When counter==ITER-1, go to DONE.
  - DONE: md_done=1 and stall=0, so the MD instruction retires this cycle; return to IDLE unconditionally. The start condition is NOT evaluated in DONE, so the still-presented instruction cannot restart.
- Timing:
  - stall is high for exactly ITER+1 consecutive cycles per MD instruction.
  - md_done follows md_start by ITER+1 cycles.
- Back-to-back MD instructions: the second one starts in the IDLE cycle after DONE, leaving a one-cycle gap.
- valid low in IDLE: no start. valid is ignored in RUN and DONE.
- ITER==1: a single RUN cycle, then DONE.
- Reset values, applied asynchronously at any time (including mid-RUN):
  - state=IDLE, counter=0, md_op=00.
  - md_start=0, md_step=0, md_done=0, md_busy=0, stall=0, illegal_op=0.
  - An aborted operation produces no md_done.
- md_busy = (state != IDLE).
- Non-MD instructions never stall.

Optional Feature:
- Macro: ALU_CONTROL_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - illegal_op is a registered one-cycle pulse, asserted the cycle after valid & alu_op==10 & funct is not in the defined set (7 ALU functs + 4 MD functs).
  - The offending instruction still decodes to alu_control=0010 and never starts MD.
  - The pulse repeats each cycle the condition holds.
- Undefined: illegal_op is tied 0 and undefined functs silently decode to 0010.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU code constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_XOR.
  - ALUOP_* encodings.
  - FUNCT_* constants.
  - MD op encodings.
  - An FSM state enum (IDLE/RUN/DONE).
- One sub-module: alu_funct_decode, a purely combinational decoder for alu_op+funct -> {alu_control, is_md, is_legal}. The top level holds the FSM and counter.

Test Plan:
- Decode sweep, no clock activity needed: each alu_op x each defined funct -> exact alu_control codes listed above. Example: alu_op=10, funct=100111 -> 1100; alu_op=01 -> 0110.
- mult with ITER=32, valid held high: md_start pulses at cycle 0 with md_op=00, md_step is high for cycles 1-32, md_done pulses at cycle 33, stall is high for cycles 0-32 (33 cycles) and low at cycle 33.
- Back-to-back divu then multu (second presented right after retirement): two md_start pulses 34 cycles apart; md_op is 11 then 01; no spurious restart in either DONE cycle.
- Assert reset asynchronously mid-RUN at iteration 10: all outputs drop to 0 without waiting for a clock edge; no md_done follows; after release, a new mult completes normally.
- With ALU_CONTROL_SEQ_ILLEGAL_TRAP_EN defined: alu_op=10, funct=111111 -> alu_control=0010, illegal_op=1 the next cycle, stall=0. Without the macro, illegal_op stays 0.
- ITER=1 build: mult -> stall for 2 cycles, md_done in the 3rd cycle; valid low in IDLE -> no start.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder and the multi-cycle MD sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // MD op is the low two bits of the MD funct.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational alu_op/funct decoder: ALU control code, MD-instruction flag, legality flag.
module alu_funct_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       is_md_o,
  output logic       is_legal_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_control_o = ALU_ADD;
    is_md_o       = 1'b0;
    is_legal_o    = 1'b1;
    case (alu_op_i)
      ALUOP_BEQ: alu_control_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALU_ADD;
          FUNCT_SUB: alu_control_o = ALU_SUB;
          FUNCT_AND: alu_control_o = ALU_AND;
          FUNCT_OR:  alu_control_o = ALU_OR;
          FUNCT_SLT: alu_control_o = ALU_SLT;
          FUNCT_NOR: alu_control_o = ALU_NOR;
          FUNCT_XOR: alu_control_o = ALU_XOR;
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: is_md_o = 1'b1;
          default:   is_legal_o = 1'b0;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control decoder plus IDLE/RUN/DONE sequencer for iterative mult/div with pipeline stall.
// Optional registered illegal-funct trap: define ALU_CONTROL_SEQ_ILLEGAL_TRAP_EN.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] instruction,
  input  logic [1:0]  alu_op,
  output logic [3:0]  alu_control,
  output logic [1:0]  md_op,
  output logic        md_start,
  output logic        md_step,
  output logic        md_done,
  output logic        md_busy,
  output logic        stall,
  output logic        illegal_op
);

  localparam int unsigned CNT_W = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  logic [5:0]       funct;
  logic             is_md;
  logic             is_legal;
  logic             md_req;
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       md_op_q, md_op_d;
  logic [25:0]      unused_instr;

  assign funct        = instruction[5:0];
  assign unused_instr = instruction[31:6];

  alu_funct_decode u_decode (
    .alu_op_i      (alu_op),
    .funct_i       (funct),
    .alu_control_o (alu_control),
    .is_md_o       (is_md),
    .is_legal_o    (is_legal)
  );

  assign md_req = valid && (alu_op == ALUOP_RTYPE) && is_md;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_op_d  = md_op_q;
    md_start = 1'b0;
    md_step  = 1'b0;
    md_done  = 1'b0;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_req) begin
          md_start = 1'b1;
          stall    = 1'b1;
          md_op_d  = funct[1:0];
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        md_step = 1'b1;
        stall   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      // The instruction retires here; it is still presented but must not restart.
      DONE: begin
        md_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      md_op_q <= MD_MULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  assign md_op   = md_op_q;
  assign md_busy = (state_q != IDLE);

`ifdef ALU_CONTROL_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= valid && (alu_op == ALUOP_RTYPE) && !is_legal;
  end

  assign illegal_op = illegal_q;
`else
  logic unused_is_legal;
  assign unused_is_legal = is_legal;
  assign illegal_op      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: decode sweep, MD sequencing, async abort, ITER=1 build.
module tb_alu_control_seq;

  localparam int ITER = 32;
`ifdef ALU_CONTROL_SEQ_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  logic        clk, reset, valid, valid1;
  logic [31:0] instruction;
  logic [1:0]  alu_op;
  logic [3:0]  alu_control, alu_control1;
  logic [1:0]  md_op, md_op1;
  logic        md_start, md_step, md_done, md_busy, stall, illegal_op;
  logic        md_start1, md_step1, md_done1, md_busy1, stall1, illegal_op1;

  alu_control_seq #(.ITER(ITER)) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .instruction(instruction), .alu_op(alu_op),
    .alu_control(alu_control), .md_op(md_op), .md_start(md_start), .md_step(md_step),
    .md_done(md_done), .md_busy(md_busy), .stall(stall), .illegal_op(illegal_op)
  );

  alu_control_seq #(.ITER(1)) u_dut1 (
    .clk(clk), .reset(reset), .valid(valid1), .instruction(instruction), .alu_op(alu_op),
    .alu_control(alu_control1), .md_op(md_op1), .md_start(md_start1), .md_step(md_step1),
    .md_done(md_done1), .md_busy(md_busy1), .stall(stall1), .illegal_op(illegal_op1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: expected MD ops pushed at issue, consumed by the monitor on md_start.
  logic [1:0] exp_q[$];
  int         start_hist[$];
  logic [1:0] cur_op;
  logic       active = 1'b0;
  int         start_cyc, stall_cnt, step_cnt;
  int         n_done = 0;

  always @(negedge clk) begin
    if (reset) begin
      active = 1'b0;
    end else begin
      if (md_start) begin
        check("start_while_busy", 32'(md_busy), 32'd0);
        check("start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) cur_op = exp_q.pop_front();
        start_hist.push_back(cyc);
        active    = 1'b1;
        start_cyc = cyc;
        stall_cnt = 0;
        step_cnt  = 0;
      end
      if (active) begin
        stall_cnt += int'(stall);
        step_cnt  += int'(md_step);
        if (md_step && step_cnt == 1) check("md_op_latched", 32'(md_op), 32'(cur_op));
      end
      if (md_done) begin
        check("done_expected", 32'(active), 32'd1);
        if (active) begin
          check("done_latency", 32'(cyc - start_cyc), 32'(ITER + 1));
          check("stall_cycles", 32'(stall_cnt), 32'(ITER + 1));
          check("step_cycles", 32'(step_cnt), 32'(ITER));
          check("stall_at_done", 32'(stall), 32'd0);
          n_done++;
        end
        active = 1'b0;
      end
    end
  end

  task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] exp);
    alu_op      = op;
    instruction = {26'h2A5A5A5, f};
    #1;
    check($sformatf("decode_%b_%b", op, f), 32'(alu_control), 32'(exp));
  endtask

  task automatic issue_md(input logic [5:0] f, input logic [1:0] op);
    @(posedge clk);
    #1;
    valid       = 1'b1;
    alu_op      = 2'b10;
    instruction = {26'h2A5A5A5, f};
    exp_q.push_back(op);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = md_done;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic drop_valid_next();
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; valid = 1'b0; valid1 = 1'b0; alu_op = 2'b00; instruction = '0;

    dec(2'b00, 6'b100000, 4'b0010);
    dec(2'b11, 6'b100010, 4'b0010);
    dec(2'b01, 6'b100010, 4'b0110);
    dec(2'b01, 6'b100100, 4'b0110);
    dec(2'b10, 6'b100000, 4'b0010);
    dec(2'b10, 6'b100010, 4'b0110);
    dec(2'b10, 6'b100100, 4'b0000);
    dec(2'b10, 6'b100101, 4'b0001);
    dec(2'b10, 6'b101010, 4'b0111);
    dec(2'b10, 6'b100111, 4'b1100);
    dec(2'b10, 6'b100110, 4'b1101);
    dec(2'b10, 6'b011000, 4'b0010);
    dec(2'b10, 6'b011011, 4'b0010);
    dec(2'b10, 6'b111111, 4'b0010);
    dec(2'b10, 6'b000000, 4'b0010);

    @(negedge clk);
    check("reset_outputs", 32'({md_start, md_step, md_done, md_busy, stall, illegal_op}), 32'd0);
    check("reset_md_op", 32'(md_op), 32'd0);
    reset = 1'b0;

    // Non-MD R-type instruction held valid: never stalls.
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 2'b10; instruction = {26'h2A5A5A5, 6'b100000};
    repeat (3) @(negedge clk);
    check("nonmd_stall", 32'({stall, md_busy}), 32'd0);

    // MD funct presented with valid low: no start.
    @(posedge clk); #1;
    valid = 1'b0; instruction = {26'h2A5A5A5, 6'b011000};
    repeat (3) @(negedge clk);
    check("novalid_stall", 32'({stall, md_busy}), 32'd0);

    issue_md(6'b011000, 2'b00);
    wait_done("mult");
    drop_valid_next();

    // divu, then multu presented in the cycle right after divu retires.
    issue_md(6'b011011, 2'b11);
    wait_done("divu");
    @(posedge clk); #1;
    instruction = {26'h2A5A5A5, 6'b011001};
    exp_q.push_back(2'b01);
    wait_done("multu");
    drop_valid_next();
    repeat (3) @(negedge clk);
    check("b2b_gap", 32'(start_hist[$] - start_hist[$-1]), 32'd34);

    // Abort mid-RUN with an asynchronous reset at iteration 10.
    issue_md(6'b011000, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = md_start;
    end
    check("abort_start_seen", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    check("abort_running", 32'({md_busy, stall, md_step}), 32'b111);
    valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({md_start, md_step, md_done, md_busy, stall, illegal_op}), 32'd0);
    check("async_reset_md_op", 32'(md_op), 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(n_done), 32'd3);

    issue_md(6'b011000, 2'b00);
    wait_done("mult_after_reset");
    drop_valid_next();

    // Undefined R-type funct.
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 2'b10; instruction = {26'h2A5A5A5, 6'b111111};
    #1;
    check("illegal_decode", 32'(alu_control), 32'b0010);
    check("illegal_stall", 32'({stall, md_start}), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    check("illegal_pulse", 32'(illegal_op), 32'(EXP_ILL));
    @(negedge clk);
    check("illegal_pulse_end", 32'(illegal_op), 32'd0);

    // ITER=1 instance: valid low gives no start, then one RUN cycle and DONE.
    @(posedge clk); #1;
    instruction = {26'h2A5A5A5, 6'b011000};
    repeat (2) @(negedge clk);
    check("iter1_novalid", 32'({stall1, md_busy1}), 32'd0);
    @(posedge clk); #1;
    valid1 = 1'b1;
    @(negedge clk);
    check("iter1_c0", 32'({md_start1, md_step1, md_done1, stall1}), 32'b1001);
    @(posedge clk); #1;
    valid1 = 1'b0;
    @(negedge clk);
    check("iter1_c1", 32'({md_start1, md_step1, md_done1, stall1}), 32'b0101);
    @(negedge clk);
    check("iter1_c2", 32'({md_start1, md_step1, md_done1, stall1}), 32'b0010);
    @(negedge clk);
    check("iter1_idle", 32'({md_busy1, stall1}), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'd4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
